// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
//
// This interface bundles the request, response and status signals of
// instr_encoder. clk and reset stay plain ports on the module.
//
// Handshake contract (applies to both the request and the response side):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   The producer holds valid and its payload stable until that edge. ready may
//   be high while valid is low. No transfer ever depends on a combinational
//   path from the same side's valid back into its own ready.
//
// Signals:
//   in_valid / in_ready       request handshake
//   in_op, in_rd, in_rn,      request payload: operation, register fields and
//   in_rm, in_imm             the signed immediate
//   out_valid / out_ready     response handshake
//   out_instr, out_err        head-of-buffer word and its error sideband
//   clr_err                   synchronous clear of err_sticky
//   err_sticky                set by any error word entering the buffer
//   words_out                 count of popped words, wraps at 2^CNT_W
//
// Modports:
//   slave  - the encoder's view
//   master - the environment's view (request source and response sink)
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [4:0]       in_rd;
  logic [4:0]       in_rn;
  logic [4:0]       in_rm;
  logic [63:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic             clr_err;
  logic             err_sticky;
  logic [CNT_W-1:0] words_out;

  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
    input  out_ready, clr_err,
    output in_ready, out_valid, out_instr, out_err, err_sticky, words_out
  );

  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
    output out_ready, clr_err,
    input  in_ready, out_valid, out_instr, out_err, err_sticky, words_out
  );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose: turns an operation request (LDUR, STUR, CBZ, ADD, SUB, AND, ORR)
// into a 32-bit ARMv8-style instruction word and queues it in a 2-entry
// buffer. Immediates that do not fit their field and the illegal op code 7
// produce an error entry (out_instr = 0, out_err = 1) instead of a word.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low reset
//   bus          if   instr_encoder_if.slave (handshakes, payload, status)
//   dbg_state_o  out  current buffer state (0 EMPTY, 1 ONE, 2 FULL)
//
// Buffer organisation: slot0 is always the head and drives the outputs
// directly; slot1 only holds the second word while FULL. Each slot stores
// {err, instr}. An emptied slot is cleared to zero so the outputs read 0
// whenever nothing is buffered.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_encoder_if.slave         bus,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LDUR = 3'd0;
  localparam logic [2:0] OP_STUR = 3'd1;
  localparam logic [2:0] OP_CBZ  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_ORR  = 3'd6;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;

  state_t           state_q, state_d;
  logic [32:0]      slot0_q, slot0_d;
  logic [32:0]      slot1_q, slot1_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] words_q, words_d;

  logic        d_fits;
  logic        cb_fits;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic [32:0] enc_entry;
  logic        push;
  logic        pop;

  // ---------------------------------------------------------------------------
  // Encoder. A value fits an N-bit signed field exactly when every bit above
  // the field's sign bit is a copy of that sign bit; sign-extending the field
  // then reproduces the original 64-bit immediate.
  // ---------------------------------------------------------------------------
  assign d_fits  = (bus.in_imm[63:8]  == {56{bus.in_imm[8]}});
  assign cb_fits = (bus.in_imm[63:18] == {46{bus.in_imm[18]}});

  always_comb begin
    enc_instr = 32'h0;
    enc_err   = 1'b0;
    case (bus.in_op)
      OP_LDUR: begin
        if (d_fits) enc_instr = {OPC_LDUR, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
        else        enc_err   = 1'b1;
      end
      OP_STUR: begin
        if (d_fits) enc_instr = {OPC_STUR, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
        else        enc_err   = 1'b1;
      end
      OP_CBZ: begin
        if (cb_fits) enc_instr = {OPC_CBZ, bus.in_imm[18:0], bus.in_rd};
        else         enc_err   = 1'b1;
      end
      OP_ADD: enc_instr = {OPC_ADD, bus.in_rm, 6'b000000, bus.in_rn, bus.in_rd};
      OP_SUB: enc_instr = {OPC_SUB, bus.in_rm, 6'b000000, bus.in_rn, bus.in_rd};
      OP_AND: enc_instr = {OPC_AND, bus.in_rm, 6'b000000, bus.in_rn, bus.in_rd};
      OP_ORR: enc_instr = {OPC_ORR, bus.in_rm, 6'b000000, bus.in_rn, bus.in_rd};
      default: enc_err = 1'b1;  // op 7 is illegal
    endcase
  end

  // An error entry always carries an all-zero instruction word.
  assign enc_entry = {enc_err, enc_instr};

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.out_instr  = slot0_q[31:0];
  assign bus.out_err    = slot0_q[32];
  assign bus.err_sticky = err_q;
  assign bus.words_out  = words_q;
  assign dbg_state_o    = state_q;

  // ---------------------------------------------------------------------------
  // Buffer FSM: next state and slot contents.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          slot0_d = enc_entry;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          slot1_d = enc_entry;
        end else if (!push && pop) begin
          state_d = EMPTY;
          slot0_d = 33'h0;
        end else if (push && pop) begin
          // Old head leaves while the new word arrives; it becomes the head.
          slot0_d = enc_entry;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_d = ONE;
          slot0_d = slot1_q;
          slot1_d = 33'h0;
        end
      end
      default: begin
        state_d = EMPTY;
        slot0_d = 33'h0;
        slot1_d = 33'h0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Status: pop counter and sticky error flag. A simultaneous clear and error
  // push leaves the flag set so that the new error is not lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    words_d = words_q;
    if (pop) words_d = words_q + CNT_W'(1);

    err_d = err_q;
    if (push && enc_err)  err_d = 1'b1;
    else if (bus.clr_err) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      slot0_q <= 33'h0;
      slot1_q <= 33'h0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed and randomised requests are driven into instr_encoder. Each
// accepted request pushes its expected {err, instr} onto exp_q; a monitor
// pops and compares whenever a word leaves the DUT. Status signals (ready,
// sticky error, pop counter, reset behaviour) are checked inline.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int CNT_W = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_encoder_if #(.CNT_W(CNT_W)) bus ();
  logic [1:0] dbg_state;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding built directly from the instruction formats.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [4:0] rd,
                                        input logic [4:0] rn, input logic [4:0] rm,
                                        input logic [63:0] imm);
    longint s;
    s = $signed(imm);
    case (op)
      3'd0: return (s >= -256 && s <= 255) ? {1'b0, 11'h7C2, imm[8:0], 2'b00, rn, rd} : {1'b1, 32'h0};
      3'd1: return (s >= -256 && s <= 255) ? {1'b0, 11'h7C0, imm[8:0], 2'b00, rn, rd} : {1'b1, 32'h0};
      3'd2: return (s >= -262144 && s <= 262143) ? {1'b0, 8'hB4, imm[18:0], rd} : {1'b1, 32'h0};
      3'd3: return {1'b0, 11'h458, rm, 6'b000000, rn, rd};
      3'd4: return {1'b0, 11'h658, rm, 6'b000000, rn, rd};
      3'd5: return {1'b0, 11'h450, rm, 6'b000000, rn, rd};
      3'd6: return {1'b0, 11'h550, rm, 6'b000000, rn, rd};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: sample on the falling edge; a word with valid && ready
  // here pops on the next rising edge.
  // ---------------------------------------------------------------------------
  logic [32:0] mon_e;
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("out_instr", 64'(bus.out_instr), 64'(mon_e[31:0]));
        chk("out_err", 64'(bus.out_err), 64'(mon_e[32]));
        pops++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_req(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [63:0] imm);
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rn    = rn;
    bus.in_rm    = rm;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
  endtask

  // Returns one time unit after the accepting edge.
  task automatic wait_accept(input logic [32:0] exp, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        exp_q.push_back(exp);
        ok = 1'b1;
      end
    end
    chk({tag, "_accepted"}, 64'(ok), 64'd1);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [63:0] imm,
                      input logic [32:0] exp, input string tag);
    drive_req(op, rd, rn, rm, imm);
    wait_accept(exp, tag);
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    @(posedge clk);
    #1;
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_empty"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1 bus.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [63:0] imm;
    int          v;

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_rd     = 5'd0;
    bus.in_rn     = 5'd0;
    bus.in_rm     = 5'd0;
    bus.in_imm    = 64'd0;
    bus.out_ready = 1'b0;
    bus.clr_err   = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_err_sticky", 64'(bus.err_sticky), 64'd0);
    chk("rst_words_out", 64'(bus.words_out), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // LDUR with one-cycle latency
    send(3'd0, 5'd1, 5'd2, 5'd0, 64'hCC, {1'b0, 32'hF84CC041}, "ldur");
    chk("ldur_latency_valid", 64'(bus.out_valid), 64'd1);
    chk("ldur_latency_instr", 64'(bus.out_instr), 64'hF84CC041);
    drain("ldur");

    // STUR, CBZ, ADD streaming
    bus.out_ready = 1'b1;
    send(3'd1, 5'd3, 5'd4, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, {1'b0, 32'hF81FF083}, "stur");
    send(3'd2, 5'd5, 5'd0, 5'd0, 64'h5555, {1'b0, 32'hB40AAAA5}, "cbz");
    send(3'd3, 5'd9, 5'd10, 5'd11, 64'h0, {1'b0, 32'h8B0B0149}, "add");
    drain("stream");

    // Error words and sticky flag
    send(3'd0, 5'd1, 5'd2, 5'd0, 64'd256, {1'b1, 32'h0}, "ldur_range");
    chk("sticky_set", 64'(bus.err_sticky), 64'd1);
    drain("range");
    pulse_clr();
    chk("sticky_clr", 64'(bus.err_sticky), 64'd0);
    send(3'd7, 5'd1, 5'd1, 5'd1, 64'd0, {1'b1, 32'h0}, "illegal_op");
    chk("sticky_illegal", 64'(bus.err_sticky), 64'd1);
    pulse_clr();
    chk("sticky_clr2", 64'(bus.err_sticky), 64'd0);
    bus.clr_err = 1'b1;
    send(3'd7, 5'd0, 5'd0, 5'd0, 64'd0, {1'b1, 32'h0}, "set_vs_clr");
    bus.clr_err = 1'b0;
    chk("sticky_set_wins", 64'(bus.err_sticky), 64'd1);
    pulse_clr();

    // Range boundaries
    send(3'd0, 5'd7, 5'd8, 5'd0, 64'd255, model(3'd0, 5'd7, 5'd8, 5'd0, 64'd255), "ldur_max");
    send(3'd0, 5'd7, 5'd8, 5'd0, -64'sd256, model(3'd0, 5'd7, 5'd8, 5'd0, -64'sd256), "ldur_min");
    send(3'd0, 5'd7, 5'd8, 5'd0, -64'sd257, {1'b1, 32'h0}, "ldur_under");
    send(3'd1, 5'd7, 5'd8, 5'd0, 64'd256, {1'b1, 32'h0}, "stur_over");
    send(3'd2, 5'd6, 5'd0, 5'd0, 64'd262143, model(3'd2, 5'd6, 5'd0, 5'd0, 64'd262143), "cbz_max");
    send(3'd2, 5'd6, 5'd0, 5'd0, -64'sd262144, model(3'd2, 5'd6, 5'd0, 5'd0, -64'sd262144), "cbz_min");
    send(3'd2, 5'd6, 5'd0, 5'd0, 64'd262144, {1'b1, 32'h0}, "cbz_over");
    send(3'd4, 5'd1, 5'd2, 5'd3, 64'h1234_5678_9ABC_DEF0, model(3'd4, 5'd1, 5'd2, 5'd3, 64'h0), "sub_imm_ignored");
    drain("bounds");
    pulse_clr();

    // Randomised requests with random backpressure
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      rn = 5'($urandom_range(0, 31));
      rm = 5'($urandom_range(0, 31));
      if (op <= 3'd1) begin
        v   = int'($urandom_range(0, 600)) - 300;
        imm = {{32{v[31]}}, v};
      end else if (op == 3'd2) begin
        v   = int'($urandom_range(0, 540000)) - 270000;
        imm = {{32{v[31]}}, v};
      end else begin
        imm = {$urandom, $urandom};
      end
      bus.out_ready = (exp_q.size() >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      send(op, rd, rn, rm, imm, model(op, rd, rn, rm, imm), "random");
    end
    drain("random");
    pulse_clr();

    // Backpressure: third request waits while the buffer is full
    do_reset();
    chk("bp_words_reset", 64'(bus.words_out), 64'd0);
    bus.out_ready = 1'b0;
    send(3'd0, 5'd1, 5'd2, 5'd0, 64'd16, model(3'd0, 5'd1, 5'd2, 5'd0, 64'd16), "bp_a");
    send(3'd5, 5'd3, 5'd4, 5'd5, 64'd0, model(3'd5, 5'd3, 5'd4, 5'd5, 64'd0), "bp_b");
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    chk("bp_state_full", 64'(dbg_state), 64'd2);
    drive_req(3'd6, 5'd6, 5'd7, 5'd8, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_wait_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_head_stable", 64'(bus.out_instr), 64'(model(3'd0, 5'd1, 5'd2, 5'd0, 64'd16)));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_accept(model(3'd6, 5'd6, 5'd7, 5'd8, 64'd0), "bp_c");
    drain("bp");
    chk("bp_words_out", 64'(bus.words_out), 64'd3);

    // Reset with a full buffer
    bus.out_ready = 1'b0;
    send(3'd7, 5'd0, 5'd0, 5'd0, 64'd0, {1'b1, 32'h0}, "rf_a");
    send(3'd3, 5'd1, 5'd1, 5'd1, 64'd0, model(3'd3, 5'd1, 5'd1, 5'd1, 64'd0), "rf_b");
    chk("rf_state_full", 64'(dbg_state), 64'd2);
    chk("rf_sticky", 64'(bus.err_sticky), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rf_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rf_words_out", 64'(bus.words_out), 64'd0);
    chk("rf_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rf_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rf_out_err", 64'(bus.out_err), 64'd0);
    chk("rf_sticky_clr", 64'(bus.err_sticky), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rf_no_word", 64'(bus.out_valid), 64'd0);
    end
    chk("rf_words_after", 64'(bus.words_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter CNT_W, default 16: width of the emitted-word counter.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  request valid.
REQ-005 in_ready  out  1  encoder can accept a request.
REQ-006 in_op  in  3  0 LDUR, 1 STUR, 2 CBZ, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 illegal.
REQ-007 in_rd  in  5  Rt for LDUR/STUR/CBZ, Rd for R-type.
REQ-008 in_rn  in  5  base register for D-type, Rn for R-type.
REQ-009 in_rm  in  5  Rm for R-type; ignored otherwise.
REQ-010 in_imm  in  64  signed two's-complement offset; ignored for R-type.
REQ-011 out_valid  out  1  encoded word available.
REQ-012 out_ready  in  1  consumer accepts the word.
REQ-013 out_instr  out  32  encoded instruction.
REQ-014 out_err  out  1  sideband: this word is invalid.
REQ-015 err_sticky  out  1  set by any error word entering the buffer.
REQ-016 clr_err  in  1  synchronous clear of err_sticky.
REQ-017 words_out  out  CNT_W  count of words popped; wraps modulo 2^CNT_W.

Function
REQ-018 The encoder is the inverse of the immediate sign-extender: its output fields, sign-extended by signext, SHALL reproduce in_imm whenever the value is in range.
REQ-019 LDUR word SHALL be {11'b11111000010, imm[8:0], 2'b00, rn, rd}; STUR SHALL use opcode 11'b11111000000 with the same fields.
REQ-020 CBZ word SHALL be {8'b10110100, imm[18:0], rd}.
REQ-021 R-type word SHALL be {opc11, rm, 6'b000000, rn, rd}, with opc11 = ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-022 Range: LDUR/STUR require -256 <= in_imm <= 255; CBZ requires -2^18 <= in_imm <= 2^18-1; R-type has no range check.
REQ-023 An out-of-range immediate or in_op = 7 SHALL produce an entry with out_instr = 32'h0 and out_err = 1.
REQ-024 A 2-entry FIFO SHALL hold encoded words; it has three states: EMPTY, ONE, FULL.
REQ-025 in_ready SHALL equal (state != FULL), combinationally.
REQ-026 out_valid SHALL equal (state != EMPTY).
REQ-027 out_instr and out_err SHALL present the head entry.
REQ-028 A request is accepted on an edge where in_valid && in_ready; the accepted word is visible on out_valid no earlier than the next cycle (latency 1).
REQ-029 A word pops on an edge where out_valid && out_ready.
REQ-030 State transitions:
- EMPTY: push -> ONE.
- ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE, with the new word becoming head.
- FULL: pop -> ONE; no push is possible.
REQ-031 Head data SHALL stay stable while out_valid && !out_ready.
REQ-032 words_out SHALL increment by 1 on each pop, including error words.
REQ-033 err_sticky SHALL set on the edge an error entry is pushed.
REQ-034 clr_err SHALL clear err_sticky; when clr_err and an error push coincide, set wins.

Reset
REQ-035 Reset assertion SHALL immediately (asynchronously) force state EMPTY, out_valid = 0, out_instr = 0, out_err = 0, err_sticky = 0 and words_out = 0.
REQ-036 in_ready SHALL read 1 during and after reset.
REQ-037 Reset mid-transfer SHALL discard all buffered words, with no pop counted.
REQ-038 Reset deassertion SHALL be synchronised by the integrator; the first accept may occur on the first edge after deassertion.

Verification
REQ-039 LDUR: op 0, rd 1, rn 2, imm 0xCC -> out_instr 32'hF84CC041, out_err 0, one cycle after accept.
REQ-040 STUR: op 1, rd 3, rn 4, imm -1 -> out_instr 32'hF81FF083; CBZ: op 2, rd 5, imm 0x5555 -> 32'hB40AAAA5.
REQ-041 ADD: op 3, rd 9, rn 10, rm 11 -> out_instr 32'h8B0B0149, out_err 0.
REQ-042 Range and illegal-op errors:
- LDUR with imm 256 -> out_instr 0, out_err 1, err_sticky 1.
- Then clr_err pulse -> err_sticky 0.
- op 7 -> out_err 1.
REQ-043 Backpressure sequence: hold out_ready 0 and push 3 requests -> in_ready 0 after the 2nd accept and the 3rd request waits. Then raise out_ready -> words emerge in order, and words_out = 3 after draining.
REQ-044 Reset with FULL buffer: assert reset -> out_valid 0 and words_out 0 at once, with no word emitted afterward.
